// File: rtl/cache_fill_pkg.sv
// rtl/cache_fill_pkg.sv - shared types and constants for the cache fill responder
package cache_fill_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 16;
  localparam int BURST_LEN  = 4;
  localparam int IDX_W      = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_FILL,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RELEASE
  } state_t;

  // Word within the line for the idx-th beat; wraps inside the 2-bit field.
  function automatic logic [IDX_W-1:0] word_sel(input logic [IDX_W-1:0] start,
                                                input logic [IDX_W-1:0] idx);
    return start + idx;
  endfunction

endpackage

// File: rtl/cache_fill_responder_if.sv
// rtl/cache_fill_responder_if.sv - cache request port and back-end word port bundle
interface cache_fill_responder_if #(
  parameter int ADDR_W = cache_fill_pkg::ADDR_W_DEF,
  parameter int DATA_W = cache_fill_pkg::DATA_W_DEF
) ();

  logic              sdram_req;
  logic              sdram_rw;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] data_to_sdram;
  logic [DATA_W-1:0] data_from_sdram;
  logic              sdram_fill;
  logic              sdram_wr_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  sdram_req, sdram_rw, sdram_addr, data_to_sdram, mem_ack, mem_rdata,
    output data_from_sdram, sdram_fill, sdram_wr_ack, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output sdram_req, sdram_rw, sdram_addr, data_to_sdram, mem_ack, mem_rdata,
    input  data_from_sdram, sdram_fill, sdram_wr_ack, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_fill_buffer.sv
// rtl/cache_fill_buffer.sv - line buffer, one write port and one registered read port
module cache_fill_buffer
  import cache_fill_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [BURST_LEN];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cache_fill_responder.sv
// rtl/cache_fill_responder.sv - fetches a 4-word line / writes one word for the cache
// Option: CACHE_FILL_CRITICAL_WORD_FIRST_EN starts the burst at sdram_addr[2:1].
module cache_fill_responder
  import cache_fill_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic clk,
  input  logic reset,
  cache_fill_responder_if.slave bus
);

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_start;
  logic [ADDR_W-4:0]   r_line;
  logic                r_fill;
  logic                r_wr_ack;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic [IDX_W-1:0]    w_start;
  logic                w_buf_we;
  logic                w_rd_en;
  logic [IDX_W-1:0]    w_rd_idx;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_last_ack;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign w_start = bus.sdram_addr[2:1];
`else
  assign w_start = '0;
`endif

  assign w_last_ack = (r_state == S_RD_WAIT) && bus.mem_ack && (r_idx == LAST_IDX);
  assign w_buf_we   = (r_state == S_RD_WAIT) && bus.mem_ack;
  // The read port runs one beat ahead so data_from_sdram lines up with sdram_fill.
  assign w_rd_en    = w_last_ack || ((r_state == S_FILL) && (r_idx != LAST_IDX));
  assign w_rd_idx   = (r_state == S_FILL) ? r_idx + 1'b1 : '0;

  cache_fill_buffer #(.DATA_W(DATA_W)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_buf_we),
    .i_wr_idx  (r_idx),
    .i_wr_data (bus.mem_rdata),
    .i_rd_en   (w_rd_en),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_start     <= '0;
      r_line      <= '0;
      r_fill      <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_wr_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.sdram_req) begin
            r_line    <= bus.sdram_addr[ADDR_W-1:3];
            r_start   <= w_start;
            r_idx     <= '0;
            r_mem_req <= 1'b1;
            if (bus.sdram_rw) begin
              r_mem_we   <= 1'b0;
              r_mem_addr <= {bus.sdram_addr[ADDR_W-1:3], w_start, 1'b0};
              r_state    <= S_RD_ISSUE;
            end else begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= bus.sdram_addr & ~ADDR_W'(1);
              r_mem_wdata <= bus.data_to_sdram;
              r_state     <= S_WR_ISSUE;
            end
          end
        end
        S_RD_ISSUE: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (bus.mem_ack) begin
            if (r_idx == LAST_IDX) begin
              r_mem_req <= 1'b0;
              r_fill    <= 1'b1;
              r_idx     <= '0;
              r_state   <= S_FILL;
            end else begin
              // mem_req stays high; the next word's address is ready for RD_ISSUE.
              r_idx      <= r_idx + 1'b1;
              r_mem_addr <= {r_line, word_sel(r_start, r_idx + 1'b1), 1'b0};
              r_state    <= S_RD_ISSUE;
            end
          end
        end
        S_FILL: begin
          if (r_idx == LAST_IDX) begin
            r_fill  <= 1'b0;
            r_state <= S_RELEASE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_WR_ISSUE: r_state <= S_WR_WAIT;
        S_WR_WAIT: begin
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_wr_ack  <= 1'b1;
            r_state   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!bus.sdram_req) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_from_sdram = w_rd_data;
  assign bus.sdram_fill      = r_fill;
  assign bus.sdram_wr_ack    = r_wr_ack;
  assign bus.mem_req         = r_mem_req;
  assign bus.mem_we          = r_mem_we;
  assign bus.mem_addr        = r_mem_addr;
  assign bus.mem_wdata       = r_mem_wdata;

endmodule

// File: tb/tb_cache_fill_responder.sv
// tb/tb_cache_fill_responder.sv - directed bench with back-end model and fill scoreboard
module tb_cache_fill_responder;

  localparam int AW = 32;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cache_fill_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cache_fill_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_fill   = 0;
  int ack_cyc  = 0;
  logic abort_ok = 1'b0;
  logic be_ack = 1'b0;
  logic stray_ack = 1'b0;
  logic [DW-1:0] base = '0;

  logic [DW-1:0] fill_q [$];
  logic [AW-1:0] addr_q [$];
  int            dly_q  [$];

  assign bus.mem_ack = be_ack | stray_ack;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Back-end: ack after one issue cycle plus the queued extra delay.
  initial begin
    int d;
    logic [AW-1:0] ea;
    bus.mem_rdata = '0;
    @(negedge clk);
    forever begin
      if (bus.mem_req === 1'b1 && reset === 1'b1) begin
        d  = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
        ea = (addr_q.size() != 0) ? addr_q.pop_front() : 'x;
        check("mem_addr", bus.mem_addr, ea);
        repeat (1 + d) @(negedge clk);
        bus.mem_rdata = base + DW'(bus.mem_addr[2:1]);
        be_ack  = 1'b1;
        ack_cyc = cyc;
        @(negedge clk);
        be_ack = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  // Fill monitor: scoreboard pop per fill beat, burst length check on each falling edge.
  initial begin
    int run;
    logic [DW-1:0] ed;
    run = 0;
    forever begin
      @(negedge clk);
      if (bus.sdram_fill === 1'b1) begin
        run++;
        n_fill++;
        ed = (fill_q.size() != 0) ? fill_q.pop_front() : 'x;
        check("fill_data", bus.data_from_sdram, ed);
      end else begin
        if (run != 0 && !abort_ok) check("fill_len", run, 4);
        run = 0;
      end
    end
  end

  task automatic start_read(input logic [AW-1:0] a, input logic [DW-1:0] b);
    logic [1:0] st;
    logic [1:0] w;
    base = b;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    st = a[2:1];
`else
    st = 2'd0;
`endif
    for (int k = 0; k < 4; k++) begin
      w = st + k[1:0];
      addr_q.push_back({a[AW-1:3], w, 1'b0});
      fill_q.push_back(b + DW'(w));
    end
    bus.sdram_addr = a;
    bus.sdram_rw   = 1'b1;
    bus.sdram_req  = 1'b1;
  endtask

  task automatic wait_fill_start(input string tag);
    int k;
    k = 0;
    while (bus.sdram_fill !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_start"}, bus.sdram_fill, 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((bus.sdram_fill !== 1'b0 || fill_q.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check({tag, "_drain"}, fill_q.size(), 0);
  endtask

  initial begin
    int c;
    int nf;
    int bad;
    int k;
    bus.sdram_req     = 1'b0;
    bus.sdram_rw      = 1'b0;
    bus.sdram_addr    = '0;
    bus.data_to_sdram = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_fill", bus.sdram_fill, 0);
    check("rst_wr_ack", bus.sdram_wr_ack, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_rdata", bus.data_from_sdram, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    reset = 1'b1;
    @(negedge clk);

    // Zero-wait read with latency checks
    start_read(32'h100, 16'hA000);
    c = cyc;
    @(negedge clk);
    check("rd_mem_req_t1", bus.mem_req, 1);
    check("rd_mem_we", bus.mem_we, 0);
    wait_fill_start("zw");
    check("zw_first_fill_lat", cyc - c, 9);
    bus.sdram_req = 1'b0;
    wait_drain("zw");

    // Critical-word-first address order (natural order when the option is off)
    start_read(32'h104, 16'hC000);
    @(negedge clk);
    wait_fill_start("cwf");
    bus.sdram_req = 1'b0;
    wait_drain("cwf");

    // Variable back-end wait
    dly_q.push_back(0);
    dly_q.push_back(3);
    dly_q.push_back(1);
    dly_q.push_back(5);
    start_read(32'h300, 16'h5000);
    @(negedge clk);
    wait_fill_start("vw");
    bus.sdram_req = 1'b0;
    wait_drain("vw");

    // Single-word write
    nf = n_fill;
    addr_q.push_back(32'h200);
    bus.sdram_addr    = 32'h200;
    bus.data_to_sdram = 16'hBEEF;
    bus.sdram_rw      = 1'b0;
    bus.sdram_req     = 1'b1;
    @(negedge clk);
    check("wr_mem_req", bus.mem_req, 1);
    check("wr_mem_we", bus.mem_we, 1);
    check("wr_mem_wdata", bus.mem_wdata, 16'hBEEF);
    k = 0;
    while (bus.sdram_wr_ack !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("wr_ack_seen", bus.sdram_wr_ack, 1);
    check("wr_ack_lat", cyc - ack_cyc, 1);
    bus.sdram_req = 1'b0;
    @(negedge clk);
    check("wr_ack_pulse", bus.sdram_wr_ack, 0);
    @(negedge clk);
    check("wr_no_fill", n_fill - nf, 0);

    // Held request: no re-service until req drops
    start_read(32'h100, 16'h7000);
    @(negedge clk);
    wait_fill_start("held");
    wait_drain("held");
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_req !== 1'b0 || bus.sdram_fill !== 1'b0) bad++;
    end
    check("held_no_reissue", bad, 0);
    bus.sdram_req = 1'b0;
    @(negedge clk);
    start_read(32'h108, 16'h7100);
    @(negedge clk);
    wait_fill_start("held2");
    bus.sdram_req = 1'b0;
    wait_drain("held2");

    // Stray ack while idle is ignored
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray_mem_req", bus.mem_req, 0);
    check("stray_wr_ack", bus.sdram_wr_ack, 0);
    check("stray_fill", bus.sdram_fill, 0);

    // Reset during the second fill beat
    start_read(32'h400, 16'h9000);
    @(negedge clk);
    wait_fill_start("rst");
    bus.sdram_req = 1'b0;
    @(negedge clk);
    abort_ok = 1'b1;
    reset    = 1'b0;
    @(negedge clk);
    check("rst_mid_fill", bus.sdram_fill, 0);
    check("rst_mid_mem_req", bus.mem_req, 0);
    reset = 1'b1;
    fill_q.delete();
    @(negedge clk);
    abort_ok = 1'b0;
    check("rst_addr_q_empty", addr_q.size(), 0);

    // Normal service after reset
    start_read(32'h100, 16'h3000);
    @(negedge clk);
    wait_fill_start("post");
    bus.sdram_req = 1'b0;
    wait_drain("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
